// File: rtl/csr_v2_pkg.sv
// Shared definitions for the machine-mode CSR unit.
// Contents:
//   - CSR address constants
//   - func3 op codes
//   - mstatus bit positions and the mcause code for an M-mode ecall
//   - FSM state encoding
//   - ecall/mret encodings
//   - a decode helper that classifies a SYSTEM instruction
package csr_v2_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  // func3 field of a SYSTEM instruction
  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_RW   = 3'b001;
  localparam logic [2:0] F3_RS   = 3'b010;
  localparam logic [2:0] F3_RC   = 3'b011;
  localparam logic [2:0] F3_RSVD = 3'b100;
  localparam logic [2:0] F3_RWI  = 3'b101;
  localparam logic [2:0] F3_RSI  = 3'b110;
  localparam logic [2:0] F3_RCI  = 3'b111;

  // mstatus fields
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MCAUSE_ECALL_M = 11;

  // Whole-instruction encodings of the two privileged ops we support
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ALU_RW = 2'd0,
    ALU_RS = 2'd1,
    ALU_RC = 2'd2
  } alu_e;

  typedef struct packed {
    logic is_csr;      // one of the six Zicsr ops
    logic is_ecall;
    logic is_mret;
    logic use_imm;     // source is the zero-extended uimm field
    logic wr_attempt;  // the op intends to write the CSR
    alu_e alu;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [2:0] f3;
    f3           = inst[14:12];
    d.is_csr     = 1'b0;
    d.is_ecall   = (inst == INST_ECALL);
    d.is_mret    = (inst == INST_MRET);
    d.use_imm    = f3[2];
    d.wr_attempt = 1'b0;
    d.alu        = ALU_RW;
    case (f3)
      F3_RW, F3_RWI: begin
        d.is_csr     = 1'b1;
        d.alu        = ALU_RW;
        d.wr_attempt = 1'b1;  // RW writes even when rd is x0
      end
      F3_RS, F3_RSI: begin
        d.is_csr     = 1'b1;
        d.alu        = ALU_RS;
        d.wr_attempt = (inst[19:15] != 5'd0);
      end
      F3_RC, F3_RCI: begin
        d.is_csr     = 1'b1;
        d.alu        = ALU_RC;
        d.wr_attempt = (inst[19:15] != 5'd0);
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/csr_unit_v2_if.sv
// Request/response channels between the WBU and the CSR unit.
//   Request:  req_valid/req_ready handshake carrying
//             req_inst (32-bit SYSTEM instruction), req_rs1 and req_pc.
//   Response: rsp_valid/rsp_ready handshake carrying
//             rsp_rdata, rsp_redirect, rsp_target and rsp_illegal.
// Modports:
//   master - the WBU side
//   slave  - the CSR unit
interface csr_unit_v2_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_inst;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_pc;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_redirect;
  logic [XLEN-1:0] rsp_target;
  logic            rsp_illegal;

  modport master (
    output req_valid, req_inst, req_rs1, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_redirect, rsp_target, rsp_illegal
  );

  modport slave (
    input  req_valid, req_inst, req_rs1, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_redirect, rsp_target, rsp_illegal
  );
endinterface

// File: rtl/csr_mcycle_counter.sv
// Free-running 64-bit cycle counter with independently writable halves.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   wr_lo, wdata_lo     - load bits [31:0] this cycle
//   wr_hi, wdata_hi     - load bits [63:32] this cycle
//   count               - current counter value
// A write replaces only its own half. The other half still takes the
// incremented value, including any carry out of the low half.
module csr_mcycle_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo,
  input  logic [31:0] wdata_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata_hi,
  output logic [63:0] count
);
  logic [63:0] count_inc;

  assign count_inc = count + 64'd1;  // wraps from all-ones to zero

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count[31:0]  <= wr_lo ? wdata_lo : count_inc[31:0];
      count[63:32] <= wr_hi ? wdata_hi : count_inc[63:32];
    end
  end
endmodule

// File: rtl/csr_unit_v2.sv
// Machine-mode CSR file.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   bus         - slave side of the request/response channels
//   mstatus_mie - live mstatus.MIE
// Operation:
//   - A request is accepted in IDLE.
//   - It is evaluated in a single EXEC cycle; all CSR updates commit on the
//     EXEC exit edge.
//   - The result is then held in RESP until rsp_ready.
//   - Throughput is one request per three cycles.
// XLEN must be 32 or 64.
module csr_unit_v2
  import csr_v2_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter logic [31:0] MVENDORID_VAL = 32'h7973_7978,
  parameter logic [31:0] MARCHID_VAL   = 32'h016F_959E,
  parameter bit          HAS_MCYCLE    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  csr_unit_v2_if.slave        bus,
  output logic                mstatus_mie
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e          state, state_nxt;

  logic [31:0]     inst_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] pc_q;

  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mepc, mcause, mscratch;
  logic [63:0]     mcycle;

  logic [XLEN-1:0] rsp_rdata_q, rsp_target_q;
  logic            rsp_redirect_q, rsp_illegal_q;

  // ---------------------------------------------------------------------
  // EXEC datapath (evaluated from the latched request)
  // ---------------------------------------------------------------------
  dec_t            dec;
  logic [11:0]     addr;
  logic [XLEN-1:0] src, mstatus_rd, old_val, new_val;
  logic            mapped, read_only, illegal, do_write;
  logic            mcycle_wr_lo, mcycle_wr_hi;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q <= '0;
      rs1_q  <= '0;
      pc_q   <= '0;
    end else if (state == ST_IDLE && bus.req_valid) begin
      inst_q <= bus.req_inst;
      rs1_q  <= bus.req_rs1;
      pc_q   <= bus.req_pc;
    end
  end

  // ---------------------------------------------------------------------
  // Decode, read mux and write value
  // ---------------------------------------------------------------------
  always_comb begin
    dec  = decode(inst_q);
    addr = inst_q[31:20];
    src  = dec.use_imm ? XLEN'(inst_q[19:15]) : rs1_q;

    // mstatus: MPP is hardwired to M-mode; only MIE/MPIE are stored
    mstatus_rd                                = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MPIE]                  = mpie;
    mstatus_rd[MSTATUS_MIE]                   = mie;

    mapped  = 1'b1;
    old_val = '0;
    case (addr)
      CSR_MSTATUS:   old_val = mstatus_rd;
      CSR_MTVEC:     old_val = mtvec;
      CSR_MSCRATCH:  old_val = mscratch;
      CSR_MEPC:      old_val = mepc;
      CSR_MCAUSE:    old_val = mcause;
      CSR_MCYCLE: begin
        mapped  = HAS_MCYCLE;
        old_val = XLEN'(mcycle);
      end
      // mcycleh only exists where mcycle cannot hold the full count
      CSR_MCYCLEH: begin
        mapped  = HAS_MCYCLE && (XLEN == 32);
        old_val = XLEN'(mcycle[63:32]);
      end
      CSR_MVENDORID: old_val = XLEN'(MVENDORID_VAL);
      CSR_MARCHID:   old_val = XLEN'(MARCHID_VAL);
      default:       mapped  = 1'b0;
    endcase

    read_only = (addr == CSR_MVENDORID) || (addr == CSR_MARCHID);

    case (dec.alu)
      ALU_RS:  new_val = old_val | src;
      ALU_RC:  new_val = old_val & ~src;
      default: new_val = src;
    endcase

    if (dec.is_csr) illegal = !mapped || (dec.wr_attempt && read_only);
    else            illegal = !(dec.is_ecall || dec.is_mret);

    do_write = (state == ST_EXEC) && dec.is_csr && dec.wr_attempt && !illegal;

    // On RV64 mcycle covers both halves; on RV32 mcycleh owns the top half.
    mcycle_wr_lo = do_write && (addr == CSR_MCYCLE);
    mcycle_wr_hi = do_write && (((addr == CSR_MCYCLE)  && (XLEN == 64)) ||
                                ((addr == CSR_MCYCLEH) && (XLEN == 32)));
  end

  // ---------------------------------------------------------------------
  // CSR state, committed on the EXEC exit edge
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mscratch <= '0;
    end else if (state == ST_EXEC) begin
      if (do_write) begin
        case (addr)
          CSR_MSTATUS: begin
            mie  <= new_val[MSTATUS_MIE];
            mpie <= new_val[MSTATUS_MPIE];
          end
          CSR_MTVEC:    mtvec    <= new_val;
          CSR_MSCRATCH: mscratch <= new_val;
          CSR_MEPC:     mepc     <= {new_val[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause   <= new_val;
          default: ;
        endcase
      end else if (dec.is_ecall) begin
        mepc   <= pc_q;
        mcause <= XLEN'(MCAUSE_ECALL_M);
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (dec.is_mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
    end
  end

  // Response registers: loaded on the EXEC exit edge, held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q    <= '0;
      rsp_redirect_q <= 1'b0;
      rsp_target_q   <= '0;
      rsp_illegal_q  <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_rdata_q    <= (dec.is_csr && !illegal) ? old_val : '0;
      rsp_redirect_q <= dec.is_ecall || dec.is_mret;
      rsp_illegal_q  <= illegal;
      if (dec.is_ecall)     rsp_target_q <= {mtvec[XLEN-1:2], 2'b00};
      else if (dec.is_mret) rsp_target_q <= mepc;
      else                  rsp_target_q <= '0;
    end
  end

  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_redirect = rsp_redirect_q;
  assign bus.rsp_target   = rsp_target_q;
  assign bus.rsp_illegal  = rsp_illegal_q;
  assign mstatus_mie      = mie;

  // ---------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------
  generate
    if (HAS_MCYCLE) begin : g_mcycle
      csr_mcycle_counter u_mcycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_lo    (mcycle_wr_lo),
        .wdata_lo (new_val[31:0]),
        .wr_hi    (mcycle_wr_hi),
        .wdata_hi (new_val[XLEN-1 -: 32]),  // [63:32] on RV64, [31:0] on RV32
        .count    (mcycle)
      );
    end else begin : g_no_mcycle
      assign mcycle = '0;
    end
  endgenerate

endmodule

// File: tb/tb_csr_unit_v2.sv
module tb_csr_unit_v2;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mie;

  csr_unit_v2_if #(.XLEN(XLEN)) bus ();

  csr_unit_v2 #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mstatus_mie (mie)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] target;
    logic        illegal;
    bit          chk_rdata;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          accept_cyc;
  logic [31:0] last_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] csr_inst(input logic [2:0] f3, input logic [11:0] addr,
                                           input logic [4:0] field);
    return {addr, field, f3, 5'd1, 7'b1110011};
  endfunction

  function automatic exp_t mk(input logic [31:0] rdata, input logic redirect,
                              input logic [31:0] target, input logic illegal,
                              input bit chk, input string name);
    exp_t e;
    e.rdata = rdata; e.redirect = redirect; e.target = target;
    e.illegal = illegal; e.chk_rdata = chk; e.name = name;
    return e;
  endfunction

  // Scoreboard monitor: compares each completed response against the queue
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got rdata=%h with nothing expected", bus.rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        last_rdata = bus.rsp_rdata;
        total++;
        if (bus.rsp_illegal !== mon_e.illegal) begin
          bad++;
          $display("FAIL %s.illegal: got %b want %b", mon_e.name, bus.rsp_illegal, mon_e.illegal);
        end
        total++;
        if (bus.rsp_redirect !== mon_e.redirect) begin
          bad++;
          $display("FAIL %s.redirect: got %b want %b", mon_e.name, bus.rsp_redirect, mon_e.redirect);
        end
        if (mon_e.redirect) begin
          total++;
          if (bus.rsp_target !== mon_e.target) begin
            bad++;
            $display("FAIL %s.target: got %h want %h", mon_e.name, bus.rsp_target, mon_e.target);
          end
        end
        if (mon_e.chk_rdata) begin
          total++;
          if (bus.rsp_rdata !== mon_e.rdata) begin
            bad++;
            $display("FAIL %s.rdata: got %h want %h", mon_e.name, bus.rsp_rdata, mon_e.rdata);
          end
        end
      end
    end
  end

  // Drive one request; returns once it has been accepted.
  task automatic send(input logic [31:0] inst, input logic [31:0] rs1,
                      input logic [31:0] pc, input exp_t e);
    int n;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_inst  = inst;
    bus.req_rs1   = rs1;
    bus.req_pc    = pc;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL %s.accept_timeout: req_ready=%b want 1", e.name, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    accept_cyc = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL rsp_timeout: pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  // Issue and wait for the response
  task automatic op(input logic [31:0] inst, input logic [31:0] rs1,
                    input logic [31:0] pc, input exp_t e);
    send(inst, rs1, pc, e);
    wait_idle();
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_redirect, bus.rsp_illegal, mie} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 10000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_redirect, bus.rsp_illegal, mie});
    end
    total++;
    if ({bus.rsp_rdata, bus.rsp_target} !== 64'h0) begin
      bad++;
      $display("FAIL reset_data: got %h/%h want 0/0", bus.rsp_rdata, bus.rsp_target);
    end
    rst_n = 1'b1;
    op(csr_inst(3'b010, 12'h300, 5'd0), 32'h0, 32'h0, mk(32'h1800, 0, 0, 0, 1, "rst_mstatus"));
    op(csr_inst(3'b010, 12'h342, 5'd0), 32'h0, 32'h0, mk(32'h0, 0, 0, 0, 1, "rst_mcause"));
  endtask

  task automatic test_rw_rs();
    op(csr_inst(3'b001, 12'h305, 5'd5), 32'h8000_0104, 32'h0, mk(32'h0, 0, 0, 0, 1, "mtvec_rw"));
    op(csr_inst(3'b010, 12'h305, 5'd0), 32'hFFFF_FFFF, 32'h0,
       mk(32'h8000_0104, 0, 0, 0, 1, "mtvec_rs_x0"));
  endtask

  task automatic test_trap();
    op(csr_inst(3'b001, 12'h300, 5'd5), 32'h0000_1888, 32'h0, mk(32'h1800, 0, 0, 0, 1, "mstatus_rw"));
    check_bit("mie_after_set", mie, 1'b1);
    op(32'h0000_0073, 32'h0, 32'h8000_0200, mk(32'h0, 1, 32'h8000_0104, 0, 1, "ecall"));
    check_bit("mie_after_ecall", mie, 1'b0);
    op(csr_inst(3'b010, 12'h341, 5'd0), 32'h0, 32'h0, mk(32'h8000_0200, 0, 0, 0, 1, "mepc_rd"));
    op(csr_inst(3'b010, 12'h342, 5'd0), 32'h0, 32'h0, mk(32'h0000_000B, 0, 0, 0, 1, "mcause_rd"));
    op(csr_inst(3'b010, 12'h300, 5'd0), 32'h0, 32'h0, mk(32'h1880, 0, 0, 0, 1, "mstatus_trap"));
    op(32'h3020_0073, 32'h0, 32'h0, mk(32'h0, 1, 32'h8000_0200, 0, 1, "mret"));
    check_bit("mie_after_mret", mie, 1'b1);
    op(csr_inst(3'b010, 12'h300, 5'd0), 32'h0, 32'h0, mk(32'h1888, 0, 0, 0, 1, "mstatus_mret"));
    // Only MIE/MPIE are writable
    op(csr_inst(3'b010, 12'h300, 5'd5), 32'hFFFF_FFFF, 32'h0, mk(32'h1888, 0, 0, 0, 1, "mstatus_rs_all"));
    op(csr_inst(3'b011, 12'h300, 5'd5), 32'hFFFF_FFFF, 32'h0, mk(32'h1888, 0, 0, 0, 1, "mstatus_rc_all"));
    op(csr_inst(3'b010, 12'h300, 5'd0), 32'h0, 32'h0, mk(32'h1800, 0, 0, 0, 1, "mstatus_cleared"));
  endtask

  task automatic test_scratch_illegal();
    op(csr_inst(3'b001, 12'h340, 5'd5), 32'h0000_00FF, 32'h0, mk(32'h0, 0, 0, 0, 1, "mscratch_rw"));
    op(csr_inst(3'b111, 12'h340, 5'd5), 32'h0, 32'h0, mk(32'hFF, 0, 0, 0, 1, "mscratch_rci"));
    op(csr_inst(3'b010, 12'h340, 5'd0), 32'h0, 32'h0, mk(32'hFA, 0, 0, 0, 1, "mscratch_rd"));
    op(csr_inst(3'b110, 12'h340, 5'd1), 32'h0, 32'h0, mk(32'hFA, 0, 0, 0, 1, "mscratch_rsi"));
    op(csr_inst(3'b101, 12'h341, 5'd3), 32'h0, 32'h0, mk(32'h8000_0200, 0, 0, 0, 1, "mepc_rwi"));
    op(csr_inst(3'b001, 12'h341, 5'd5), 32'h8000_0203, 32'h0, mk(32'h0, 0, 0, 0, 1, "mepc_rw"));
    op(csr_inst(3'b010, 12'h341, 5'd0), 32'h0, 32'h0, mk(32'h8000_0200, 0, 0, 0, 1, "mepc_align"));
    op(csr_inst(3'b010, 12'h340, 5'd0), 32'h0, 32'h0, mk(32'hFB, 0, 0, 0, 1, "mscratch_rd2"));
    op(csr_inst(3'b001, 12'hF11, 5'd5), 32'h1234_5678, 32'h0, mk(32'h0, 0, 0, 1, 1, "mvendorid_rw"));
    op(csr_inst(3'b010, 12'hF11, 5'd0), 32'h0, 32'h0, mk(32'h7973_7978, 0, 0, 0, 1, "mvendorid_rd"));
    op(csr_inst(3'b110, 12'hF12, 5'd0), 32'h0, 32'h0, mk(32'h016F_959E, 0, 0, 0, 1, "marchid_rsi0"));
    op(csr_inst(3'b110, 12'hF12, 5'd2), 32'h0, 32'h0, mk(32'h0, 0, 0, 1, 1, "marchid_rsi"));
    op(csr_inst(3'b010, 12'h7C0, 5'd0), 32'h0, 32'h0, mk(32'h0, 0, 0, 1, 1, "unmapped"));
    op(csr_inst(3'b001, 12'h340, 5'd0), 32'h0, 32'h0, mk(32'hFB, 0, 0, 0, 1, "mscratch_rw_x0"));
    op(csr_inst(3'b100, 12'h340, 5'd0), 32'h0, 32'h0, mk(32'h0, 0, 0, 1, 1, "func3_100"));
    op(32'h0010_0073, 32'h0, 32'h0, mk(32'h0, 0, 0, 1, 1, "ebreak"));
    op(csr_inst(3'b010, 12'h340, 5'd0), 32'h0, 32'h0, mk(32'h0, 0, 0, 0, 1, "mscratch_after"));
  endtask

  task automatic test_backpressure();
    logic [31:0] s_rdata, s_target;
    logic        s_redir, s_ill;
    int          n;
    bus.rsp_ready = 1'b0;
    send(csr_inst(3'b010, 12'h305, 5'd0), 32'h0, 32'h0, mk(32'h8000_0104, 0, 0, 0, 1, "bp_mtvec"));
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_bit("bp_rsp_valid", bus.rsp_valid, 1'b1);
    s_rdata = bus.rsp_rdata; s_target = bus.rsp_target;
    s_redir = bus.rsp_redirect; s_ill = bus.rsp_illegal;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_rdata !== s_rdata ||
          bus.rsp_target !== s_target || bus.rsp_redirect !== s_redir || bus.rsp_illegal !== s_ill) begin
        bad++;
        $display("FAIL bp_stable[%0d]: valid=%b ready=%b rdata=%h want valid=1 ready=0 rdata=%h",
                 i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata, s_rdata);
      end
    end
    bus.rsp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_inst  = csr_inst(3'b001, 12'h305, 5'd5);
    bus.req_rs1   = 32'hABCD_0000;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);  // now in EXEC
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_bit("rstmid_rsp_valid", bus.rsp_valid, 1'b0);
    check_bit("rstmid_req_ready", bus.req_ready, 1'b1);
    repeat (2) @(negedge clk);
    check_bit("rstmid_rsp_valid_hold", bus.rsp_valid, 1'b0);
    rst_n = 1'b1;
    op(csr_inst(3'b010, 12'h305, 5'd0), 32'h0, 32'h0, mk(32'h0, 0, 0, 0, 1, "rstmid_mtvec"));
    op(csr_inst(3'b010, 12'h300, 5'd0), 32'h0, 32'h0, mk(32'h1800, 0, 0, 0, 1, "rstmid_mstatus"));
  endtask

  task automatic test_mcycle();
    logic [31:0] v1, v2;
    int          c1, c2;
    op(csr_inst(3'b001, 12'hB80, 5'd5), 32'h0, 32'h0, mk(32'h0, 0, 0, 0, 0, "mcycleh_rw"));
    op(csr_inst(3'b001, 12'hB00, 5'd5), 32'hFFFF_FFFF, 32'h0, mk(32'h0, 0, 0, 0, 0, "mcycle_rw"));
    op(csr_inst(3'b010, 12'hB80, 5'd0), 32'h0, 32'h0, mk(32'h1, 0, 0, 0, 1, "mcycleh_carry"));
    op(csr_inst(3'b010, 12'hB00, 5'd0), 32'h0, 32'h0, mk(32'h0, 0, 0, 0, 0, "mcycle_rd1"));
    v1 = last_rdata; c1 = accept_cyc;
    repeat (10) @(negedge clk);
    op(csr_inst(3'b010, 12'hB00, 5'd0), 32'h0, 32'h0, mk(32'h0, 0, 0, 0, 0, "mcycle_rd2"));
    v2 = last_rdata; c2 = accept_cyc;
    total++;
    if ((v2 - v1) !== 32'(c2 - c1)) begin
      bad++;
      $display("FAIL mcycle_delta: got %0d want %0d", v2 - v1, c2 - c1);
    end
    total++;
    if (v1 > 32'd1000) begin
      bad++;
      $display("FAIL mcycle_low_wrapped: got %h want small value after wrap", v1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_inst  = 32'h0;
    bus.req_rs1   = 32'h0;
    bus.req_pc    = 32'h0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_rw_rs();
    test_trap();
    test_scratch_illegal();
    test_backpressure();
    test_reset_mid();
    test_mcycle();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_unit_v2.md
Name: csr_unit_v2

Overview:
- Parametrised machine-mode CSR file for the in-order core, fed by the WBU over a valid/ready request channel.
- Returns the old CSR value and any control-flow redirect on a separate valid/ready response channel.
- Generalises the previous CSR block:
  - XLEN-parametric.
  - Full Zicsr op set (RW/RS/RC plus immediate forms).
  - mscratch and a free-running 64-bit mcycle.
  - mstatus MIE/MPIE trap semantics on ecall/mret.
  - Illegal-access reporting.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- MVENDORID_VAL, 32'h79737978, read-only value for mvendorid, zero-extended to XLEN.
- MARCHID_VAL, 32'h016F959E, read-only value for marchid, zero-extended to XLEN.
- HAS_MCYCLE, 1, when 0, mcycle/mcycleh are absent and accesses to them are illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high together with req_valid
- req_inst  in  32  SYSTEM instruction (opcode 1110011)
- req_rs1  in  XLEN  rs1 register value
- req_pc  in  XLEN  pc of the instruction
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  XLEN  CSR value before the write (0 for ecall/mret/illegal)
- rsp_redirect  out  1  pc must be redirected
- rsp_target  out  XLEN  redirect target
- rsp_illegal  out  1  illegal CSR access
- mstatus_mie  out  1  live mstatus.MIE

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE; req_ready=1.
  - All rsp_* outputs are 0.
  - mstatus=0x1800 (MPP=11); mtvec, mepc, mcause, mscratch and mcycle are 0.
  - Reset mid-transaction drops the request; no partial CSR write.
- FSM IDLE -> EXEC -> RESP -> IDLE:
  - req_ready=1 only in IDLE.
  - The accepting edge latches inst, rs1 and pc, then moves to EXEC.
  - EXEC lasts one cycle. It computes the old value and the new value and commits all CSR writes on the exit edge.
  - RESP drives rsp_valid=1; rsp_* stay stable until rsp_ready=1, then the FSM returns to IDLE.
  - Minimum accept-to-rsp_valid latency is 2 cycles. Back-to-back throughput is one request per 3 cycles.
- Decode (func3 = inst[14:12], addr = inst[31:20], src = rs1 for 001/010/011, zero-extended inst[19:15] for 101/110/111):
  - RW: new = src.
  - RS: new = old | src.
  - RC: new = old & ~src.
  - For RS/RC, an inst[19:15]==0 field means no write attempt.
  - RW always writes, including when rd==0.
  - func3 000 with inst==0x00000073 is ecall; inst==0x30200073 is mret. Any other func3 000 or 100 encoding is illegal.
- Address map:
  - 300 mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 11; other bits read 0.
  - 305 mtvec, 340 mscratch, 341 mepc (bits[1:0] forced 0 on write), 342 mcause.
  - B00 mcycle: the low XLEN bits.
  - B80 mcycleh: upper 32 bits; exists only when XLEN=32.
  - F11 mvendorid, F12 marchid: read-only.
- Illegal cases:
  - Any unmapped address.
  - Any write attempt to F11/F12.
  - Effect: rsp_illegal=1, rsp_rdata=0, no CSR changes.
- ecall:
  - mepc=pc, mcause=11.
  - MPIE=MIE, MIE=0.
  - rsp_redirect=1, rsp_target={mtvec[XLEN-1:2],2'b00}.
- mret:
  - MIE=MPIE, MPIE=1.
  - rsp_redirect=1, rsp_target=mepc.
- mcycle:
  - 64-bit; increments every cycle after reset regardless of FSM state; wraps from all-ones to 0.
  - A CSR write to mcycle or mcycleh on the EXEC exit edge takes priority over the increment for that half only. The other half still follows the increment, including carry.
  - The value read is the value at EXEC.

Decomposition:
- Package csr_v2_pkg:
  - CSR address localparams.
  - func3 op codes.
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - mcause code ECALL_M=11.
  - 2-bit FSM state encoding.
  - ecall/mret instruction constants.
- One sub-module, csr_mcycle_counter:
  - 64-bit counter with per-half write enables and write data.
  - Increment-vs-write priority as above.
  - Asynchronous active-low reset.

Test Plan:
- Reset then csrrw 0x305 with rs1=0x80000104 -> rsp_rdata=0, rsp_illegal=0; a later csrrs 0x305 with x0 -> rsp_rdata=0x80000104, rsp_redirect=0.
- mstatus=0x1888 (csrrw); ecall at pc=0x80000200 -> rsp_redirect=1, rsp_target=0x80000104; mepc reads 0x80000200, mcause reads 0xB, mstatus reads 0x1880.
- mret after the previous case -> rsp_target=0x80000200; mstatus reads 0x1888.
- csrrci 0x340 imm=5 with mscratch=0xFF -> rsp_rdata=0xFF; mscratch reads 0xFA. csrrw 0xF11 -> rsp_illegal=1; csrrs 0xF11 with x0 -> rsp_rdata=0x79737978, rsp_illegal=0.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout. Assert rst_n during EXEC -> no CSR write and rsp_valid=0.
- csrrw mcycle=0xFFFFFFFF with mcycleh=0 (XLEN=32) -> two cycles later mcycleh reads 1. Reading mcycle twice, 10 cycles apart -> difference equals 10 plus the request overhead.
